// File: rtl/mrc_lane_read_cntl.sv
// mrc_lane_read_cntl: parses MR descriptors, issues credit-limited SRAM reads
// and streams the returned words as a SOM/MOM/EOM-framed lane.
module mrc_lane_read_cntl #(
  parameter int OPT_PER_INST = 3,
  parameter int OPT_TYPE_W   = 4,
  parameter int OPT_VALUE_W  = 16,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_poweron,
  input  logic                                     wud__mrc__valid,
  output logic                                     mrc__wud__ready,
  input  logic [1:0]                               wud__mrc__cntl,
  input  logic [OPT_PER_INST-1:0][OPT_TYPE_W-1:0]  wud__mrc__option_type,
  input  logic [OPT_PER_INST-1:0][OPT_VALUE_W-1:0] wud__mrc__option_value,
  output logic                                     mrc__sram__rd_en,
  output logic [ADDR_W-1:0]                        mrc__sram__rd_addr,
  input  logic [DATA_W-1:0]                        sram__mrc__rd_data,
  output logic                                     mrc__std__lane_valid,
  output logic [1:0]                               mrc__std__lane_cntl,
  input  logic                                     std__mrc__lane_ready,
  output logic [DATA_W-1:0]                        mrc__std__lane_data,
  output logic                                     mrc__sys__desc_err,
  output logic                                     mrc__sys__busy
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + MEM_LAT + 2) + 1;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_READ, S_DRAIN} state_t;
  state_t r_state;
  logic r_ready, r_err, r_rd_en;
  logic [ADDR_W-1:0] r_addr, r_rd_addr, w_addr;
  logic [OPT_VALUE_W-1:0] r_cnt, r_rem, r_emit, w_cnt;
  logic [MEM_LAT-1:0] r_tag;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [FCW-1:0] r_fcnt;
  logic [CW-1:0] w_infl;
  logic w_acc, w_push, w_pop, w_issue;

  assign w_acc  = wud__mrc__valid && r_ready;
  assign w_push = r_tag[MEM_LAT-1];
  assign w_pop  = mrc__std__lane_valid && std__mrc__lane_ready;
  // Every read in flight or buffered holds a FIFO slot; a pop this cycle frees one.
  assign w_infl  = CW'($countones(r_tag)) + CW'(r_rd_en) + CW'(r_fcnt);
  assign w_issue = r_state == S_READ && r_rem != '0 && (w_infl - CW'(w_pop)) < CW'(FIFO_DEPTH);

  assign mrc__wud__ready      = r_ready;
  assign mrc__sram__rd_en     = r_rd_en;
  assign mrc__sram__rd_addr   = r_rd_addr;
  assign mrc__sys__desc_err   = r_err;
  assign mrc__sys__busy       = r_state != S_IDLE;
  assign mrc__std__lane_valid = r_fcnt != '0;
  assign mrc__std__lane_data  = mrc__std__lane_valid ? r_mem[r_rp] : '0;
  assign mrc__std__lane_cntl  = !mrc__std__lane_valid ? 2'b00 :
                                r_cnt == OPT_VALUE_W'(1) ? 2'b11 :
                                r_emit == '0 ? 2'b01 :
                                r_emit == r_cnt - OPT_VALUE_W'(1) ? 2'b10 : 2'b00;

  always_comb begin
    w_addr = wud__mrc__cntl[0] ? '0 : r_addr;
    w_cnt  = wud__mrc__cntl[0] ? '0 : r_cnt;
    for (int i = 0; i < OPT_PER_INST; i++) begin
      if (wud__mrc__option_type[i] == OPT_TYPE_W'(1)) w_addr = ADDR_W'(wud__mrc__option_value[i]);
      if (wud__mrc__option_type[i] == OPT_TYPE_W'(2)) w_cnt = wud__mrc__option_value[i];
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_emit    <= '0;
    end else begin
      r_err   <= 1'b0;
      r_rd_en <= 1'b0;
      if (w_pop) r_emit <= r_emit + OPT_VALUE_W'(1);
      case (r_state)
        S_IDLE, S_COLLECT: begin
          r_ready <= 1'b1;
          if (w_acc) begin
            if (r_state == S_IDLE && !wud__mrc__cntl[0]) r_err <= 1'b1;
            else begin
              r_addr <= w_addr;
              r_cnt  <= w_cnt;
              if (r_state == S_COLLECT && wud__mrc__cntl[0]) r_err <= 1'b1;
              if (!wud__mrc__cntl[1]) r_state <= S_COLLECT;
              else if (w_cnt == '0) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_READ;
                r_ready <= 1'b0;
                r_rem   <= w_cnt;
                r_emit  <= '0;
              end
            end
          end
        end
        S_READ:
          if (w_issue) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_addr;
            r_addr    <= r_addr + ADDR_W'(1);
            r_rem     <= r_rem - OPT_VALUE_W'(1);
            if (r_rem == OPT_VALUE_W'(1)) r_state <= S_DRAIN;
          end
        S_DRAIN:
          if (w_pop && r_emit == r_cnt - OPT_VALUE_W'(1)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_tag  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      r_tag  <= MEM_LAT'({r_tag, r_rd_en});
      r_fcnt <= r_fcnt + FCW'(w_push) - FCW'(w_pop);
      if (w_push) r_wp <= r_wp == PW'(FIFO_DEPTH - 1) ? '0 : r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp == PW'(FIFO_DEPTH - 1) ? '0 : r_rp + PW'(1);
    end
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= sram__mrc__rd_data;
endmodule

// File: tb/tb_mrc_lane_read_cntl.sv
// tb_mrc_lane_read_cntl: directed checks of descriptor parsing, read issue,
// credit limiting, stream framing and reset recovery.
module tb_mrc_lane_read_cntl;
  localparam int T = 10;
  logic clk = 1'b0;
  logic reset_poweron = 1'b1;
  logic wud__mrc__valid = 1'b0;
  logic mrc__wud__ready;
  logic [1:0] wud__mrc__cntl = 2'b00;
  logic [2:0][3:0] wud__mrc__option_type = '0;
  logic [2:0][15:0] wud__mrc__option_value = '0;
  logic mrc__sram__rd_en;
  logic [15:0] mrc__sram__rd_addr;
  logic [31:0] sram__mrc__rd_data;
  logic mrc__std__lane_valid;
  logic [1:0] mrc__std__lane_cntl;
  logic std__mrc__lane_ready = 1'b1;
  logic [31:0] mrc__std__lane_data;
  logic mrc__sys__desc_err;
  logic mrc__sys__busy;
  int n_chk = 0;
  int n_err = 0;
  int max_inf = 0;
  int b_rd, b_s;
  logic [15:0] rd_q [$];
  logic [31:0] s_data [$];
  logic [1:0] s_cntl [$];
  longint s_t [$];
  logic [31:0] p0, p1;

  mrc_lane_read_cntl dut (
    .clk(clk),
    .reset_poweron(reset_poweron),
    .wud__mrc__valid(wud__mrc__valid),
    .mrc__wud__ready(mrc__wud__ready),
    .wud__mrc__cntl(wud__mrc__cntl),
    .wud__mrc__option_type(wud__mrc__option_type),
    .wud__mrc__option_value(wud__mrc__option_value),
    .mrc__sram__rd_en(mrc__sram__rd_en),
    .mrc__sram__rd_addr(mrc__sram__rd_addr),
    .sram__mrc__rd_data(sram__mrc__rd_data),
    .mrc__std__lane_valid(mrc__std__lane_valid),
    .mrc__std__lane_cntl(mrc__std__lane_cntl),
    .std__mrc__lane_ready(std__mrc__lane_ready),
    .mrc__std__lane_data(mrc__std__lane_data),
    .mrc__sys__desc_err(mrc__sys__desc_err),
    .mrc__sys__busy(mrc__sys__busy)
  );

  always #(T / 2) clk = ~clk;

  function automatic logic [31:0] mdata(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Two-cycle SRAM: data appears two cycles after the rd_en cycle.
  always @(posedge clk) begin
    p0 <= mrc__sram__rd_en ? mdata(mrc__sram__rd_addr) : 32'hDEAD_BEEF;
    p1 <= p0;
  end
  assign sram__mrc__rd_data = p1;

  always @(posedge clk) begin
    if (mrc__sram__rd_en) rd_q.push_back(mrc__sram__rd_addr);
    if (mrc__std__lane_valid && std__mrc__lane_ready) begin
      s_data.push_back(mrc__std__lane_data);
      s_cntl.push_back(mrc__std__lane_cntl);
      s_t.push_back($time);
    end
  end

  always @(negedge clk)
    if (rd_q.size() - s_data.size() > max_inf) max_inf <= rd_q.size() - s_data.size();

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [1:0] c, input logic [3:0] t0, input logic [15:0] v0,
                      input logic [3:0] t1, input logic [15:0] v1,
                      input logic [3:0] t2, input logic [15:0] v2);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    wud__mrc__valid = 1'b1;
    wud__mrc__cntl = c;
    wud__mrc__option_type = {t2, t1, t0};
    wud__mrc__option_value = {v2, v1, v0};
    for (int k = 0; k < 20 && !acc; k++) begin
      @(posedge clk);
      acc = mrc__wud__ready;
    end
    #1 wud__mrc__valid = 1'b0;
    if (!acc) chk("beat_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!mrc__sys__busy) break;
    end
    chk(tag, 32'(mrc__sys__busy), 32'd0);
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] a0, input int n);
    logic [15:0] a;
    chk({tag, "_rdcnt"}, 32'(rd_q.size() - b_rd), 32'(n));
    for (int k = 0; k < n && b_rd + k < rd_q.size(); k++) begin
      a = a0 + 16'(k);
      chk($sformatf("%s_rdaddr%0d", tag, k), 32'(rd_q[b_rd + k]), 32'(a));
    end
  endtask

  task automatic chk_stream(input string tag, input logic [15:0] a0, input int n);
    logic [15:0] a;
    logic [1:0] c;
    chk({tag, "_wcnt"}, 32'(s_data.size() - b_s), 32'(n));
    for (int k = 0; k < n && b_s + k < s_data.size(); k++) begin
      a = a0 + 16'(k);
      c = n == 1 ? 2'b11 : k == 0 ? 2'b01 : k == n - 1 ? 2'b10 : 2'b00;
      chk($sformatf("%s_data%0d", tag, k), s_data[b_s + k], mdata(a));
      chk($sformatf("%s_cntl%0d", tag, k), 32'(s_cntl[b_s + k]), 32'(c));
    end
  endtask

  task automatic mark;
    b_rd = rd_q.size();
    b_s = s_data.size();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(mrc__wud__ready), 32'd0);
    chk("rst_rd_en", 32'(mrc__sram__rd_en), 32'd0);
    chk("rst_valid", 32'(mrc__std__lane_valid), 32'd0);
    chk("rst_cntl", 32'(mrc__std__lane_cntl), 32'd0);
    chk("rst_data", mrc__std__lane_data, 32'd0);
    chk("rst_busy", 32'(mrc__sys__busy), 32'd0);
    chk("rst_err", 32'(mrc__sys__desc_err), 32'd0);
    reset_poweron = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(mrc__wud__ready), 32'd1);

    // single-word SOM_EOM descriptor and its exact latency
    mark();
    beat(2'b11, 4'd1, 16'h0010, 4'd2, 16'h0001, 4'd0, 16'h0000);
    @(negedge clk);
    chk("t1_rd_en_n0", 32'(mrc__sram__rd_en), 32'd0);
    @(negedge clk);
    chk("t1_rd_en_n1", 32'(mrc__sram__rd_en), 32'd1);
    chk("t1_rd_addr", 32'(mrc__sram__rd_addr), 32'h0010);
    @(negedge clk);
    chk("t1_rd_en_n2", 32'(mrc__sram__rd_en), 32'd0);
    chk("t1_valid_n2", 32'(mrc__std__lane_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_n3", 32'(mrc__std__lane_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_n4", 32'(mrc__std__lane_valid), 32'd1);
    chk("t1_cntl_n4", 32'(mrc__std__lane_cntl), 32'd3);
    chk("t1_data_n4", mrc__std__lane_data, mdata(16'h0010));
    chk("t1_err", 32'(mrc__sys__desc_err), 32'd0);
    wait_idle("t1_idle");
    chk_rd("t1", 16'h0010, 1);
    chk_stream("t1", 16'h0010, 1);

    // two beats, last START_ADDR wins across beats; full-rate stream
    mark();
    beat(2'b01, 4'd1, 16'h0100, 4'd0, 16'h0000, 4'd0, 16'h0000);
    beat(2'b10, 4'd2, 16'h0005, 4'd1, 16'h0200, 4'd0, 16'h0000);
    wait_idle("t2_idle");
    chk_rd("t2", 16'h0200, 5);
    chk_stream("t2", 16'h0200, 5);
    if (s_t.size() >= b_s + 5) chk("t2_span", 32'(s_t[b_s + 4] - s_t[b_s]), 32'(4 * T));

    // address wrap at 0xFFFF
    mark();
    beat(2'b11, 4'd1, 16'hFFFE, 4'd2, 16'h0004, 4'd7, 16'h1234);
    wait_idle("t3_idle");
    chk_rd("t3", 16'hFFFE, 4);
    chk_stream("t3", 16'hFFFE, 4);

    // backpressure: reads stop at FIFO_DEPTH credits
    mark();
    std__mrc__lane_ready = 1'b0;
    beat(2'b11, 4'd1, 16'h0300, 4'd2, 16'h0008, 4'd0, 16'h0000);
    repeat (10) @(negedge clk);
    chk("t4_stall_reads", 32'(rd_q.size() - b_rd), 32'd4);
    chk("t4_stall_valid", 32'(mrc__std__lane_valid), 32'd1);
    chk("t4_stall_cntl", 32'(mrc__std__lane_cntl), 32'd1);
    chk("t4_stall_busy", 32'(mrc__sys__busy), 32'd1);
    std__mrc__lane_ready = 1'b1;
    wait_idle("t4_idle");
    if (s_t.size() > 0) chk("t4_busy_drop", 32'($time - s_t[s_t.size() - 1]), 32'(T / 2));
    chk_rd("t4", 16'h0300, 8);
    chk_stream("t4", 16'h0300, 8);
    chk("t4_max_inflight", 32'(max_inf), 32'd4);

    // zero-count descriptor and stray MOM
    mark();
    beat(2'b11, 4'd2, 16'h0000, 4'd1, 16'h0055, 4'd0, 16'h0000);
    @(negedge clk);
    chk("t5_err_hi", 32'(mrc__sys__desc_err), 32'd1);
    chk("t5_busy", 32'(mrc__sys__busy), 32'd0);
    @(negedge clk);
    chk("t5_err_lo", 32'(mrc__sys__desc_err), 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_no_rd", 32'(rd_q.size() - b_rd), 32'd0);
    beat(2'b00, 4'd1, 16'h0077, 4'd2, 16'h0003, 4'd0, 16'h0000);
    @(negedge clk);
    chk("t5_mom_err_hi", 32'(mrc__sys__desc_err), 32'd1);
    chk("t5_mom_busy", 32'(mrc__sys__busy), 32'd0);
    @(negedge clk);
    chk("t5_mom_err_lo", 32'(mrc__sys__desc_err), 32'd0);
    chk("t5_mom_ready", 32'(mrc__wud__ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_mom_no_rd", 32'(rd_q.size() - b_rd), 32'd0);

    // reset in DRAIN with two words buffered, then a fresh transfer
    std__mrc__lane_ready = 1'b0;
    beat(2'b11, 4'd1, 16'h0500, 4'd2, 16'h0002, 4'd0, 16'h0000);
    repeat (8) @(negedge clk);
    chk("t6_pre_valid", 32'(mrc__std__lane_valid), 32'd1);
    chk("t6_pre_busy", 32'(mrc__sys__busy), 32'd1);
    reset_poweron = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(mrc__std__lane_valid), 32'd0);
    chk("t6_rst_busy", 32'(mrc__sys__busy), 32'd0);
    @(negedge clk);
    reset_poweron = 1'b0;
    std__mrc__lane_ready = 1'b1;
    @(negedge clk);
    chk("t6_ready", 32'(mrc__wud__ready), 32'd1);
    chk("t6_valid", 32'(mrc__std__lane_valid), 32'd0);
    mark();
    beat(2'b11, 4'd1, 16'h0040, 4'd2, 16'h0002, 4'd0, 16'h0000);
    wait_idle("t6_idle");
    chk_rd("t6", 16'h0040, 2);
    chk_stream("t6", 16'h0040, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #(20000 * T);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
